// File: rtl/ci_pkg.sv
// Shared types and width helpers for the CI window-mean stage.
package ci_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DIV  = 2'd2
  } ci_state_e;

  // Width needed to hold the sum of `size` unsigned values of `width` bits.
  function automatic int unsigned sum_width(input int unsigned width,
                                            input int unsigned size);
    return width + $clog2(size);
  endfunction

endpackage

// File: rtl/ci_serial_div.sv
// Bit-serial restoring divider by a constant: one quotient bit per cycle,
// MSB first, N cycles after i_load. o_quot/o_done describe the step being
// taken this cycle so the caller can register the final quotient on the
// same edge that completes the division.
module ci_serial_div #(
  parameter int unsigned N       = 13,
  parameter int unsigned DIVISOR = 25,
  parameter int unsigned QW      = N
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [N-1:0]  i_dividend,
  output logic [QW-1:0] o_quot,
  output logic          o_done
);

  localparam int unsigned RW = $clog2(DIVISOR) + 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [RW:0] DIV_C = (RW + 1)'(DIVISOR);

  logic [RW-1:0] rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q;
  logic          active_q;
  logic [RW:0]   trial;
  logic          fits;

  // One restoring step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits, and shift the quotient bit in.
  always_comb begin
    trial  = {rem_q, quo_q[N-1]};
    fits   = (trial >= DIV_C);
    rem_d  = fits ? RW'(trial - DIV_C) : RW'(trial);
    quo_d  = {quo_q[N-2:0], fits};
    o_quot = quo_d[QW-1:0];
    o_done = active_q && (cnt_q == CW'(N - 1));
  end

  // Dividend and quotient share one shift register; the counter bounds the run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (i_load) begin
      rem_q    <= '0;
      quo_q    <= i_dividend;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CW'(1);
      if (o_done) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ci_window_mean.sv
// Serial window sum, divide-by-SIZE mean and centre-vs-mean compare.
// Results are registered and announced with a one-cycle o_valid pulse.
module ci_window_mean
  import ci_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned SIZE   = 25,
  parameter  int unsigned CENTER = 12,
  localparam int unsigned SUM_W  = sum_width(WIDTH, SIZE)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_win [SIZE],
  output logic             o_busy,
  output logic             o_valid,
  output logic [SUM_W-1:0] o_sum,
  output logic [WIDTH-1:0] o_mean,
  output logic             o_ci
);

  localparam int unsigned IW = $clog2(SIZE);

  ci_state_e        state_q;
  logic [IW-1:0]    idx_q;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] center_q;
  logic             busy_q, valid_q, ci_q;
  logic [SUM_W-1:0] sum_q;
  logic [WIDTH-1:0] mean_q;
  logic             last_add;
  logic             div_load;
  logic [WIDTH-1:0] div_quot;
  logic             div_done;

  // Next accumulator value and the hand-off into the divider on the last add.
  always_comb begin
    acc_d    = acc_q + SUM_W'(i_win[idx_q]);
    last_add = (idx_q == IW'(SIZE - 1));
    div_load = (state_q == ACC) && last_add;
  end

  ci_serial_div #(
    .N       (SUM_W),
    .DIVISOR (SIZE),
    .QW      (WIDTH)
  ) u_div (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (div_load),
    .i_dividend (acc_d),
    .o_quot     (div_quot),
    .o_done     (div_done)
  );

  // Control FSM with accumulator and registered result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      center_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sum_q    <= '0;
      mean_q   <= '0;
      ci_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            center_q <= i_win[CENTER];
            acc_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          if (last_add) begin
            idx_q   <= '0;
            state_q <= DIV;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DIV: begin
          if (div_done) begin
            sum_q   <= acc_q;
            mean_q  <= div_quot;
            ci_q    <= (center_q >= div_quot);
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_mean  = mean_q;
  assign o_ci    = ci_q;

endmodule

// File: tb/tb_ci_window_mean.sv
// Bench for ci_window_mean: directed windows, ignored starts, back-to-back
// runs and mid-run reset, with expected results queued at stimulus time.
module tb_ci_window_mean;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SIZE   = 25;
  localparam int unsigned CENTER = 12;
  localparam int unsigned SUM_W  = 13;
  localparam int          LAT    = 38;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] mean;
    logic             ci;
  } res_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] win [SIZE];
  logic             o_busy, o_valid, o_ci;
  logic [SUM_W-1:0] o_sum;
  logic [WIDTH-1:0] o_mean;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];

  ci_window_mean #(
    .WIDTH  (WIDTH),
    .SIZE   (SIZE),
    .CENTER (CENTER)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_win   (win),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_sum   (o_sum),
    .o_mean  (o_mean),
    .o_ci    (o_ci)
  );

  always #5 clk = ~clk;

  function automatic res_t model();
    int unsigned s = 0;
    res_t r;
    for (int i = 0; i < SIZE; i++) s += win[i];
    r.sum  = SUM_W'(s);
    r.mean = WIDTH'(s / SIZE);
    r.ci   = (win[CENTER] >= r.mean);
    return r;
  endfunction

  function automatic res_t got_res();
    return {o_sum, o_mean, o_ci};
  endfunction

  task automatic fill(input int unsigned v);
    for (int i = 0; i < SIZE; i++) win[i] = WIDTH'(v);
  endtask

  task automatic fill_random();
    for (int i = 0; i < SIZE; i++) win[i] = WIDTH'($urandom_range(1, 255));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for o_valid (lat = cycles since the start edge, 0 on timeout)
  // and pops the matching expectation.
  task automatic wait_valid(input int budget, output int lat, output res_t e);
    lat = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = n;
        break;
      end
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++;
    if (got_res() !== res_t'(0)) begin
      bad++; $display("FAIL reset_outputs got sum=%0d mean=%0d ci=%b want all 0", o_sum, o_mean, o_ci);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Directed run with a fixed expected result; also checks busy and pulse width.
  task automatic test_directed(input string name, input res_t want);
    int   lat;
    res_t e;
    exp_q.push_back(want);
    pulse_start();
    total++;
    if (o_busy !== 1'b1) begin bad++; $display("FAIL %s_busy_rise got=%b want=1", name, o_busy); end
    wait_valid(100, lat, e);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, LAT); end
    total++;
    if (got_res() !== e) begin
      bad++; $display("FAIL %s_result got sum=%0d mean=%0d ci=%b want sum=%0d mean=%0d ci=%b",
                      name, o_sum, o_mean, o_ci, e.sum, e.mean, e.ci);
    end
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL %s_busy_fall got=%b want=0", name, o_busy); end
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_width got=%b want=0", name, o_valid); end
    repeat (3) @(negedge clk);
    total++;
    if (got_res() !== e) begin
      bad++; $display("FAIL %s_hold got sum=%0d mean=%0d ci=%b want sum=%0d mean=%0d ci=%b",
                      name, o_sum, o_mean, o_ci, e.sum, e.mean, e.ci);
    end
  endtask

  task automatic test_values();
    test_directed("all100", res_t'{sum: 13'd2500, mean: 8'd100, ci: 1'b1});
    fill(255);
    test_directed("all255", res_t'{sum: 13'd6375, mean: 8'd255, ci: 1'b1});
    for (int i = 0; i < SIZE; i++) win[i] = WIDTH'(i);
    test_directed("ramp", res_t'{sum: 13'd300, mean: 8'd12, ci: 1'b1});
    fill(255);
    win[CENTER] = '0;
    test_directed("center0", res_t'{sum: 13'd6120, mean: 8'd244, ci: 1'b0});
  endtask

  task automatic test_ignore_start();
    int   nvalid = 0;
    int   lat    = 0;
    res_t e      = '0;
    fill_random();
    exp_q.push_back(model());
    pulse_start();
    for (int n = 1; n <= 80; n++) begin
      start = (n == 5 || n == 20);
      @(negedge clk);
      if (o_valid) begin
        nvalid++;
        if (nvalid == 1) begin
          lat = n;
          e   = exp_q.pop_front();
          total++;
          if (got_res() !== e) begin
            bad++; $display("FAIL ignore_result got sum=%0d mean=%0d ci=%b want sum=%0d mean=%0d ci=%b",
                            o_sum, o_mean, o_ci, e.sum, e.mean, e.ci);
          end
        end
      end
    end
    start = 1'b0;
    total++;
    if (nvalid !== 1) begin bad++; $display("FAIL ignore_count got=%0d want=1", nvalid); end
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int   k      = 0;
    int   prev_n = 0;
    res_t e;
    fill_random();
    repeat (3) exp_q.push_back(model());
    start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (o_valid) begin
        k++;
        e = exp_q.pop_front();
        total++;
        if (got_res() !== e) begin
          bad++; $display("FAIL b2b_result%0d got sum=%0d mean=%0d ci=%b want sum=%0d mean=%0d ci=%b",
                          k, o_sum, o_mean, o_ci, e.sum, e.mean, e.ci);
        end
        if (k > 1) begin
          total++;
          if (n - prev_n !== LAT + 1) begin
            bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", k, n - prev_n, LAT + 1);
          end
        end
        prev_n = n;
        if (k == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    total++;
    if (k !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", k); end
    @(negedge clk);
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_reset_abort();
    int   lat;
    res_t e;
    fill_random();
    pulse_start();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_busy, o_valid} !== 2'b00) begin
      bad++; $display("FAIL abort_flags got busy=%b valid=%b want 0 0", o_busy, o_valid);
    end
    total++;
    if (got_res() !== res_t'(0)) begin
      bad++; $display("FAIL abort_outputs got sum=%0d mean=%0d ci=%b want all 0", o_sum, o_mean, o_ci);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(7);
    exp_q.push_back(res_t'{sum: 13'd175, mean: 8'd7, ci: 1'b1});
    pulse_start();
    wait_valid(100, lat, e);
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL abort_rerun_latency got=%0d want=%0d", lat, LAT); end
    total++;
    if (got_res() !== e) begin
      bad++; $display("FAIL abort_rerun_result got sum=%0d mean=%0d ci=%b want sum=%0d mean=%0d ci=%b",
                      o_sum, o_mean, o_ci, e.sum, e.mean, e.ci);
    end
  endtask

  initial begin
    fill(100);
    test_reset();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ci_window_mean.md
# ci_window_mean

Sequential mean-and-compare stage in the MRELBP CI path. It sits directly downstream of `hold_value` and consumes its `SIZE`-element window array. On a start pulse it serially sums the window, divides by `SIZE` with a bit-serial restoring divider, and compares the centre pixel to the mean. It emits the mean, the sum and the CI bit with a one-cycle valid pulse.

## Interface
Parameters:
- `WIDTH`, 8, pixel width; must match the upstream hold stage.
- `SIZE`, 25, number of window elements (5x5).
- `CENTER`, 12, index of the centre pixel within the window.
- Derived, not overridable: `SUM_W` = `WIDTH + $clog2(SIZE)` (13 at defaults).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `i_clk`  in  1  clock.
  - `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  request a computation; sampled only in IDLE.
- `i_win`  in  `[WIDTH-1:0] [SIZE-1:0]` (unpacked)  window from the hold stage.
- `o_busy`  out  1  high in ACC and DIV.
- `o_valid`  out  1  one-cycle pulse when results update.
- `o_sum`  out  `SUM_W`  sum of all window elements.
- `o_mean`  out  `WIDTH`  floor(`o_sum` / `SIZE`).
- `o_ci`  out  1  1 if `i_win[CENTER]` >= `o_mean` (unsigned), else 0.

## Operation
- FSM states: IDLE, ACC, DIV.
- IDLE:
  - `i_start`=1: capture `i_win[CENTER]` into `center_q`, clear the accumulator, set `idx`=0, go to ACC.
  - Otherwise stay in IDLE.
- ACC: each cycle, `acc += i_win[idx]` and `idx++`.
  - After the add with `idx`=`SIZE-1`, load the divider and go to DIV.
  - `i_win` must be stable from the start edge until the ACC→DIV transition. Changes during ACC corrupt the result, by contract.
- DIV: restoring division of `acc` by constant `SIZE`, one quotient bit per cycle, MSB first, `SUM_W` cycles.
  - Partial remainder width: `$clog2(SIZE)+1`.
  - On the final step, register `o_sum`, `o_mean` (low `WIDTH` bits of the quotient) and `o_ci`; pulse `o_valid`; return to IDLE.
- Arithmetic:
  - Accumulator width is `SUM_W`; it cannot overflow, since `SIZE*(2^WIDTH-1)` < `2^SUM_W`.
  - The quotient is at most `2^WIDTH-1`, so truncation to `WIDTH` bits is exact.
- Boundary conditions:
  - `i_start` while busy is ignored, not queued.
  - `i_start` held high produces back-to-back computations. A new computation starts on the edge after `o_valid`.
  - Outputs hold their last result until the next `o_valid`.
- Reset:
  - Asserting `i_rst_n` low at any time, including mid-ACC or mid-DIV, aborts the computation and returns to IDLE.
  - Reset values: `o_busy`=0, `o_valid`=0, `o_sum`=0, `o_mean`=0, `o_ci`=0, `idx`=0, accumulator=0.

## Timing
- Edge numbering: edge 0 is the `i_start` sample edge.
- `o_busy` rises after edge 0.
- ACC adds occur on edges 1..`SIZE`.
- DIV steps occur on edges `SIZE+1`..`SIZE+SUM_W`.
- `o_valid` is high for exactly the cycle following edge `SIZE+SUM_W` (edge 38 at defaults); `o_busy` falls on the same edge.
- Start-to-valid latency: `SIZE+SUM_W` cycles (38 at defaults).
- Minimum spacing between results: `SIZE+SUM_W+1` cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `ci_pkg` holds:
  - the `ci_state_e` enum (IDLE, ACC, DIV);
  - the `sum_width(WIDTH, SIZE)` constant function.
- Sub-module `ci_serial_div`: parameterised bit-serial restoring divider with a constant divisor.
  - Ports: `i_load`, `i_dividend`, `o_quot`, `o_done`.
  - The top module instantiates it in DIV and owns the FSM and accumulator.

## Test plan
- All 25 pixels = 100, pulse start → 38 cycles later `o_valid`=1 for one cycle, `o_sum`=2500, `o_mean`=100, `o_ci`=1.
- All 255 → `o_sum`=6375, `o_mean`=255, `o_ci`=1 (no overflow).
- `i_win[k]`=k for k=0..24 → `o_sum`=300, `o_mean`=12, `o_ci`=1 (centre 12 >= 12).
- Centre 0, others 255 → `o_sum`=6120, `o_mean`=244 (floor of 244.8), `o_ci`=0.
- Pulse start again at cycles 5 and 20 of a run → ignored; exactly one `o_valid` per accepted start. With start held high, successive valids are 39 cycles apart.
- Assert `i_rst_n` at cycle 10 of ACC → all outputs 0 immediately. After release plus a new start with all pixels = 7, the run yields `o_mean`=7, with no residue from the aborted run.
